uart_rx_pkt_ctrl: RTL

//  Packet-level controller behind the multi-lane uart_rx frame receiver. Consumes per-frame

---
 rtl/phy_types_pkg.sv | 19 +
 rtl/socetlib_counter.sv | 35 +++
 rtl/uart_rx_pkt_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/phy_types_pkg.sv
// Shared PHY types: uart_rx frame classification and packet controller states.
package phy_types_pkg;

    typedef enum logic [1:0] {
        NADA         = 2'd0,
        COMMA_1_FLIT = 2'd1,
        COMMA_2_FLIT = 2'd2,
        COMMA_DATA   = 2'd3
    } comma_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } rx_ctrl_state_t;

    localparam int RX_PKT_MAX_FRAMES = 2;

endpackage

// File: rtl/socetlib_counter.sv
// Up-counter with synchronous clear that wraps after reaching overflow_val.
module socetlib_counter #(
    parameter int NBITS = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [NBITS-1:0] overflow_val,
    output logic             overflow_flag
);

    logic [NBITS-1:0] count_q;
    logic [NBITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == overflow_val) ? '0 : count_q + NBITS'(1);
        end
    end

    assign overflow_flag = count_enable & (count_q == overflow_val);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: assembles header+data frames and commits whole packets.
module uart_rx_pkt_ctrl
    import phy_types_pkg::*;
#(
    parameter  int PORTCOUNT = 5,
    parameter  int TIMEOUT   = 64,
    parameter  int CNT_W     = 8,
    localparam int FRAME_W   = 10 * PORTCOUNT
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 rx_done,
    input  logic                 rx_err,
    input  comma_sel_t           rx_comma_sel,
    input  logic [FRAME_W-1:0]   rx_data,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [2*FRAME_W-1:0] pkt_data,
    output logic                 pkt_len,
    output logic                 busy,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 proto_err
);

    localparam int IDX_W = $clog2(RX_PKT_MAX_FRAMES + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    rx_ctrl_state_t       state_q, state_d;
    logic                 done_q;
    logic [IDX_W-1:0]     need_q, need_d, idx_q, idx_d;
    logic [FRAME_W-1:0]   stage0_q, stage0_d, stage1_q, stage1_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic [2*FRAME_W-1:0] pkt_data_q, pkt_data_d;
    logic                 pkt_len_q, pkt_len_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic                 perr_q, perr_d;
    logic [1:0]           drop_inc;
    logic                 perr_set;
    logic [CNT_W:0]       drop_sum;
    logic                 tmo_clear, tmo_hit;
    logic                 frame_evt, is_hdr, is_data;

    assign frame_evt = rx_done & ~done_q;
    assign is_hdr    = frame_evt & ((rx_comma_sel == COMMA_1_FLIT) | (rx_comma_sel == COMMA_2_FLIT));
    assign is_data   = frame_evt & (rx_comma_sel == COMMA_DATA);

    socetlib_counter #(
        .NBITS(TMO_W)
    ) u_timeout (
        .CLK          (CLK),
        .nRST         (nRST),
        .clear        (tmo_clear),
        .count_enable (state_q == COLLECT),
        .overflow_val (TMO_MAX),
        .overflow_flag(tmo_hit)
    );

    always_comb begin
        state_d     = state_q;
        need_d      = need_q;
        idx_d       = idx_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        pkt_valid_d = pkt_valid_q & ~pkt_ready;
        pkt_data_d  = pkt_data_q;
        pkt_len_d   = pkt_len_q;
        drop_inc    = 2'd0;
        perr_set    = 1'b0;
        tmo_clear   = 1'b1;

        case (state_q)
            IDLE, COMMIT: begin
                if (state_q == COMMIT) begin
                    // The slot is free if empty or being drained on this very edge.
                    if (!pkt_valid_q || pkt_ready) begin
                        pkt_valid_d = 1'b1;
                        pkt_len_d   = (need_q == IDX_W'(2));
                        pkt_data_d  = (need_q == IDX_W'(2)) ? {stage1_q, stage0_q}
                                                             : {{FRAME_W{1'b0}}, stage0_q};
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                    state_d = IDLE;
                end
                if (is_hdr) begin
                    state_d = COLLECT;
                    need_d  = (rx_comma_sel == COMMA_2_FLIT) ? IDX_W'(2) : IDX_W'(1);
                    idx_d   = '0;
                end else if (is_data) begin
                    perr_set = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                end
            end
            COLLECT: begin
                tmo_clear = 1'b0;
                if (rx_err) begin
                    perr_set = 1'b1;
                    drop_inc = 2'd1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end else if (is_hdr) begin
                    drop_inc  = 2'd1;
                    need_d    = (rx_comma_sel == COMMA_2_FLIT) ? IDX_W'(2) : IDX_W'(1);
                    idx_d     = '0;
                    tmo_clear = 1'b1;
                end else if (is_data) begin
                    if (idx_q == '0) begin
                        stage0_d = rx_data;
                    end else begin
                        stage1_d = rx_data;
                    end
                    idx_d     = idx_q + IDX_W'(1);
                    tmo_clear = 1'b1;
                    if (idx_q + IDX_W'(1) == need_q) begin
                        state_d = COMMIT;
                    end
                end else if (tmo_hit) begin
                    drop_inc = 2'd1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);
        drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        perr_d   = perr_q | perr_set;
        if (clr_stats) begin
            drop_d = '0;
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            need_q      <= '0;
            idx_q       <= '0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_len_q   <= 1'b0;
            drop_q      <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= rx_done;
            need_q      <= need_d;
            idx_q       <= idx_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_len_q   <= pkt_len_d;
            drop_q      <= drop_d;
            perr_q      <= perr_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_data  = pkt_data_q;
    assign pkt_len   = pkt_len_q;
    assign busy      = (state_q != IDLE);
    assign drop_cnt  = drop_q;
    assign proto_err = perr_q;

endmodule
